// File: rtl/aes_core_arbiter_pkg.sv
// Shared definitions for the masked-AES core arbiter: FSM encoding,
// requester-count bounds and index-width/wrap helpers.
package aes_core_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_e;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    function automatic bit nreq_in_range(input int n);
        return (n >= NREQ_MIN) && (n <= NREQ_MAX);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Explicit modulo wrap so non-power-of-2 counts never yield an index >= n.
    function automatic int next_index(input int g, input int n);
        return (g >= n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/aes_core_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request at ptr, ptr+1, ... (mod NREQ).
module rr_priority_select
    import aes_core_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] grant,
    output logic            any_req
);

    always_comb begin
        int             k;
        logic [IDXW-1:0] idx;
        k       = 0;
        idx     = '0;
        grant   = '0;
        any_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            idx = k[IDXW-1:0];
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one 32-bit masked AES core among NREQ requesters;
// tracks ownership of the single in-flight encryption and returns ciphertext to its owner.
`ifndef NSHARES
`define NSHARES 2
`endif

module aes_core_arbiter
    import aes_core_arbiter_pkg::*;
#(
    parameter int d    = `NSHARES,
    parameter int NREQ = 2,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*128*d-1:0] req_sh_plaintext,
    input  logic [NREQ*128*d-1:0] req_sh_key,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [NREQ*128*d-1:0] resp_sh_ciphertext,
    output logic                  core_valid_in,
    input  logic                  core_in_ready,
    output logic [128*d-1:0]      core_sh_plaintext,
    output logic [128*d-1:0]      core_sh_key,
    input  logic                  core_cipher_valid,
    output logic                  core_out_ready,
    input  logic [128*d-1:0]      core_sh_ciphertext,
    output logic [IDXW-1:0]       owner,
    output logic                  arb_busy
);

    localparam int SHW = 128 * d;

    if (!nreq_in_range(NREQ)) begin : g_nreq_check
        $error("aes_core_arbiter: NREQ out of range");
    end

    // Selection on a public control bit applied uniformly to a whole sharing.
    function automatic logic [SHW-1:0] mux_gate(input logic sel, input logic [SHW-1:0] a);
        return a & {SHW{sel}};
    endfunction

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] rr_grant;
    logic            any_req;
    logic            issue_sel;
    logic            deliver_sel;

    rr_priority_select #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_select (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (rr_grant),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        req_ready      = '0;
        resp_valid     = '0;
        core_valid_in  = 1'b0;
        core_out_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = rr_grant;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_valid_in      = req_valid[grant_q];
                req_ready[grant_q] = core_in_ready & req_valid[grant_q];
                if (req_valid[grant_q] && core_in_ready) begin
                    state_d = ST_WAIT;
                end else if (!req_valid[grant_q]) begin
                    // Withdrawn request gives up its turn so others cannot starve.
                    ptr_d   = IDXW'(next_index(int'(grant_q), NREQ));
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (core_cipher_valid) begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                resp_valid[grant_q] = core_cipher_valid;
                core_out_ready      = resp_ready[grant_q];
                if (core_cipher_valid && resp_ready[grant_q]) begin
                    ptr_d   = IDXW'(next_index(int'(grant_q), NREQ));
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign issue_sel   = (state_q == ST_ISSUE);
    assign deliver_sel = (state_q == ST_DELIVER);

    always_comb begin
        core_sh_plaintext = '0;
        core_sh_key       = '0;
        for (int r = 0; r < NREQ; r++) begin
            core_sh_plaintext |= mux_gate(issue_sel && (grant_q == IDXW'(r)),
                                          req_sh_plaintext[r*SHW +: SHW]);
            core_sh_key       |= mux_gate(issue_sel && (grant_q == IDXW'(r)),
                                          req_sh_key[r*SHW +: SHW]);
        end
    end

    always_comb begin
        resp_sh_ciphertext = '0;
        for (int r = 0; r < NREQ; r++) begin
            resp_sh_ciphertext[r*SHW +: SHW] =
                mux_gate(deliver_sel && core_cipher_valid && (grant_q == IDXW'(r)),
                         core_sh_ciphertext);
        end
    end

    assign owner    = grant_q;
    assign arb_busy = (state_q != ST_IDLE);

endmodule
